// File: rtl/hilo_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : hilo_div_unit_if
// Purpose  : Request/result bundle between EX pipeline control and the
//            HI/LO divider.
// Revision : 1.0  initial release
// ============================================================================
interface hilo_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             annul_i;
  logic             signed_div_i;
  logic [WIDTH-1:0] opdata1_i;
  logic [WIDTH-1:0] opdata2_i;
  logic             busy_o;
  logic             ready_o;
  logic             we_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  busy_o, ready_o, we_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output busy_o, ready_o, we_o, hi_o, lo_o
  );
endinterface
`default_nettype wire

// File: rtl/hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_div_unit
// Purpose  : Multi-cycle restoring 32/32 divider producing HI (remainder) and
//            LO (quotient). Define DIV_EARLY_OUT_EN for the |a|<|b| shortcut.
// Revision : 1.0  initial release
// ============================================================================
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  hilo_div_unit_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BYZERO = 3'd1;
  localparam logic [2:0] S_SHORT  = 3'd2;
  localparam logic [2:0] S_ON     = 3'd3;
  localparam logic [2:0] S_END    = 3'd4;

  logic [2:0]       state_q,    state_d;
  logic [CW-1:0]    count_q,    count_d;
  logic [2*WIDTH:0] pr_q,       pr_d;
  logic [WIDTH-1:0] divisor_q,  divisor_d;
  logic             quot_neg_q, quot_neg_d;
  logic             rem_neg_q,  rem_neg_d;
  logic [WIDTH-1:0] hi_q,       hi_d;
  logic [WIDTH-1:0] lo_q,       lo_d;
  logic             we_done_q,  we_done_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             accept;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH:0] step;
  logic             busy, ready, we;

  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  // Operand magnitudes and one restoring-division step
  always_comb begin
    dvd_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    dvs_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    dvd_mag = neg_if(dvd_neg, bus.opdata1_i);
    dvs_mag = neg_if(dvs_neg, bus.opdata2_i);
    accept  = bus.start_i & ~bus.annul_i;
    shifted = pr_q << 1;
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_q};
    step    = trial[WIDTH] ? shifted : {trial, shifted[WIDTH-1:1], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      pr_q       <= '0;
      divisor_q  <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      we_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pr_q       <= pr_d;
      divisor_q  <= divisor_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      we_done_q  <= we_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pr_d       = pr_q;
    divisor_d  = divisor_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    // Marks END cycles after the entry cycle so the write strobe fires once
    we_done_d  = (state_q == S_END);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          divisor_d  = dvs_mag;
          pr_d       = {{(WIDTH+1){1'b0}}, dvd_mag};
          quot_neg_d = dvd_neg ^ dvs_neg;
          rem_neg_d  = dvd_neg;
          count_d    = '0;
          if (bus.opdata2_i == '0) begin
            state_d = S_BYZERO;
`ifdef DIV_EARLY_OUT_EN
          end else if (dvd_mag < dvs_mag) begin
            state_d = S_SHORT;
`endif
          end else begin
            state_d = S_ON;
          end
        end
      end
      S_BYZERO: begin
        if (bus.annul_i) begin
          state_d = S_IDLE;
        end else begin
          hi_d    = '0;
          lo_d    = '0;
          state_d = S_END;
        end
      end
      S_SHORT: begin
        if (bus.annul_i) begin
          state_d = S_IDLE;
        end else begin
          hi_d    = neg_if(rem_neg_q, pr_q[WIDTH-1:0]);
          lo_d    = '0;
          state_d = S_END;
        end
      end
      S_ON: begin
        if (bus.annul_i) begin
          state_d = S_IDLE;
        end else begin
          pr_d    = step;
          count_d = count_q + CW'(1);
          if (count_q == LAST_COUNT) begin
            lo_d    = neg_if(quot_neg_q, step[WIDTH-1:0]);
            hi_d    = neg_if(rem_neg_q, step[2*WIDTH-1:WIDTH]);
            state_d = S_END;
          end
        end
      end
      S_END: begin
        if (!bus.start_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == S_BYZERO) || (state_q == S_SHORT) || (state_q == S_ON);
    ready = (state_q == S_END);
    we    = (state_q == S_END) && !we_done_q;
  end

  assign bus.busy_o  = busy;
  assign bus.ready_o = ready;
  assign bus.we_o    = we;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_div_unit
// Purpose  : Self-checking bench for hilo_div_unit (vector table, corner
//            sequences, randomized operations against an arithmetic model).
// Revision : 1.0  initial release
// ============================================================================
module tb_hilo_div_unit;

  localparam int W = 32;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  hilo_div_unit_if #(.WIDTH(W)) bus ();
  hilo_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Plain arithmetic reference: SV division truncates toward zero and the
  // remainder follows the dividend, which is exactly DIV/DIVU semantics.
  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
    longint sa, sb, ma, mb;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0; lat = 2;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      lat = W + 1;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) lat = 2;
`else
      if (ma < mb) lat = W + 1;
`endif
    end
  endfunction

  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input string nm);
    logic [31:0] eq, er;
    int exp_lat, lat, wes;
    bit got;
    ref_div(sgn, a, b, eq, er, exp_lat);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    lat = 0; wes = 0; got = 1'b0;
    while (!got && lat < 100) begin
      tick();
      lat++;
      if (lat == 1) begin
        check({nm, " busy"}, longint'(bus.busy_o), 1);
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~sgn;
      end
      if (bus.we_o) wes++;
      if (bus.ready_o) got = 1'b1;
    end
    if (!got) begin
      check({nm, " timeout"}, 0, 1);
      bus.start_i = 1'b0;
      tick();
      return;
    end
    check({nm, " latency"}, longint'(lat), longint'(exp_lat));
    check({nm, " lo"}, longint'(bus.lo_o), longint'(eq));
    check({nm, " hi"}, longint'(bus.hi_o), longint'(er));
    check({nm, " we_first"}, longint'(wes), 1);
    tick();
    check({nm, " ready_hold"}, longint'(bus.ready_o), 1);
    check({nm, " we_once"}, longint'(bus.we_o), 0);
    bus.start_i = 1'b0;
    tick();
    check({nm, " idle_ready"}, longint'({bus.ready_o, bus.busy_o, bus.we_o}), 0);
    check({nm, " lo_hold"}, longint'(bus.lo_o), longint'(eq));
  endtask

  vec_t vecs[10];

  initial begin
    int wes, rdy;
    bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0; bus.opdata2_i = '0;

    vecs[0] = '{0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3] = '{1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[4] = '{0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[5] = '{0, 32'd5,          32'd0,          32'd0,          32'd0};
    vecs[6] = '{0, 32'd3,          32'd10,         32'd0,          32'd3};
    vecs[7] = '{1, 32'hFFFF_FFFD,  32'd10,         32'd0,          32'hFFFF_FFFD};
    vecs[8] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
    vecs[9] = '{0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};

    tick(); tick();
    check("reset_flags", longint'({bus.busy_o, bus.ready_o, bus.we_o}), 0);
    check("reset_hilo", longint'({bus.hi_o, bus.lo_o}), 0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      logic [31:0] q, r;
      int l;
      ref_div(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, l);
      check($sformatf("vec%0d model_lo", i), longint'(q), longint'(vecs[i].exp_lo));
      check($sformatf("vec%0d model_hi", i), longint'(r), longint'(vecs[i].exp_hi));
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
    end

    // Annul at ON count=10: no write, results untouched
    run_op(0, 32'd100, 32'd7, "pre_annul");
    bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
    bus.start_i = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) tick();
    check("annul_busy_before", longint'(bus.busy_o), 1);
    bus.annul_i = 1'b1; bus.start_i = 1'b0;
    tick();
    bus.annul_i = 1'b0;
    check("annul_busy_after", longint'(bus.busy_o), 0);
    wes = 0; rdy = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.we_o) wes++;
      if (bus.ready_o) rdy++;
      tick();
    end
    check("annul_no_we", longint'(wes), 0);
    check("annul_no_ready", longint'(rdy), 0);
    check("annul_hilo_hold", longint'({bus.hi_o, bus.lo_o}), longint'({32'd2, 32'd14}));

    // Reset in the middle of an ON sequence
    bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7; bus.start_i = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) tick();
    check("rst_mid_busy", longint'(bus.busy_o), 1);
    rst = 1'b0;
    tick();
    check("rst_mid_flags", longint'({bus.busy_o, bus.ready_o, bus.we_o}), 0);
    check("rst_mid_hilo", longint'({bus.hi_o, bus.lo_o}), 0);
    bus.start_i = 1'b0;
    rst = 1'b1;
    tick();
    run_op(0, 32'd9, 32'd3, "restart");

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      bit s;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: a = 32'($urandom_range(0, 50));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op(s, a, b, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
